sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH independent set/reset storage bits with a shared mode: SR, JK, D or T next-state rule per clock. It replaces single-bit SR flops and makes S=R=1 defined behaviour through a synthesis-time conflict policy. Per-channel sticky conflict flags, a saturating conflict-cycle counter and one-cycle change pulses let control logic monitor illegal stimulus. It sits between control FSMs and status and indicator registers.

---
 rtl/sr_ff_pkg.sv | 53 +++++
 rtl/sr_ff_cell.sv | 52 +++++
 rtl/sr_ff_bank.sv | 74 +++++++
 tb/tb_sr_ff_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared encodings and the per-bit next-state rule for the set/reset flop bank.
package sr_ff_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned CONF_W = 2;

  localparam logic [MODE_W-1:0] MODE_SR = 2'd0;
  localparam logic [MODE_W-1:0] MODE_JK = 2'd1;
  localparam logic [MODE_W-1:0] MODE_D  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_T  = 2'd3;

  localparam logic [CONF_W-1:0] CONF_HOLD = 2'd0;
  localparam logic [CONF_W-1:0] CONF_SET  = 2'd1;
  localparam logic [CONF_W-1:0] CONF_RST  = 2'd2;
  localparam logic [CONF_W-1:0] CONF_TOG  = 2'd3;

  // Next stored value of one channel; r is ignored in D and T modes.
  function automatic logic next_q(input logic q, input logic s, input logic r,
                                  input logic [MODE_W-1:0] mode,
                                  input logic [CONF_W-1:0] policy);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b01:   nq = 1'b0;
          2'b10:   nq = 1'b1;
          2'b11: begin
            case (policy)
              CONF_SET: nq = 1'b1;
              CONF_RST: nq = 1'b0;
              CONF_TOG: nq = ~q;
              default:  nq = q;
            endcase
          end
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b01:   nq = 1'b0;
          2'b10:   nq = 1'b1;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = s;
      default: nq = q ^ s;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One storage channel: state bit, change pulse and sticky conflict flag.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int unsigned CONFLICT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              s,
  input  logic              r,
  input  logic              err_clr,
  output logic              q,
  output logic              changed,
  output logic              err_flag,
  output logic              conflict_c
);

  logic q_q, q_d;
  logic changed_q, changed_d;
  logic err_flag_q, err_flag_d;

  always_comb begin
    q_d        = q_q;
    changed_d  = 1'b0;
    conflict_c = en & (mode == MODE_SR) & s & r;
    if (en) begin
      q_d       = next_q(q_q, s, r, mode, CONF_W'(CONFLICT));
      changed_d = q_d ^ q_q;
    end
    // A conflict in the clearing cycle survives the clear.
    err_flag_d = (err_clr ? 1'b0 : err_flag_q) | conflict_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q        <= 1'b0;
      changed_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign q        = q_q;
  assign changed  = changed_q;
  assign err_flag = err_flag_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH set/reset channels sharing a mode, with a saturating conflict counter.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CONFLICT = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  s,
  input  logic [WIDTH-1:0]  r,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  changed,
  output logic [WIDTH-1:0]  err_flag,
  output logic [CNT_W-1:0]  err_cnt
);

  if (CONFLICT > 3) begin : g_bad_conflict
    $error("sr_ff_bank: CONFLICT must be 0..3");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sr_ff_bank: WIDTH must be at least 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("sr_ff_bank: CNT_W must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] conflict_vec;
  logic             conflict_any;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(.CONFLICT(CONFLICT)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .s          (s[i]),
      .r          (r[i]),
      .err_clr    (err_clr),
      .q          (q[i]),
      .changed    (changed[i]),
      .err_flag   (err_flag[i]),
      .conflict_c (conflict_vec[i])
    );
  end

  assign conflict_any = |conflict_vec;

  // Counts conflicting cycles, not channels; clear and increment may coincide.
  always_comb begin
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    if (conflict_any && (err_cnt_d != CNT_MAX)) begin
      err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: directed vectors queue expectations, a monitor checks each edge.
module tb_sr_ff_bank;

  localparam logic [1:0] M_SR = 2'd0;
  localparam logic [1:0] M_JK = 2'd1;
  localparam logic [1:0] M_D  = 2'd2;
  localparam logic [1:0] M_T  = 2'd3;

  typedef struct {
    logic [7:0] q;
    logic [7:0] ch;
    logic [7:0] ef;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  // DUT A: WIDTH=8, set-dominant, 2-bit counter
  logic       a_en, a_clr;
  logic [1:0] a_mode;
  logic [7:0] a_s, a_r, a_q, a_ch, a_ef;
  logic [1:0] a_cnt;
  // DUT B: WIDTH=4, reset-dominant
  logic       b_en, b_clr;
  logic [1:0] b_mode;
  logic [3:0] b_s, b_r, b_q, b_ch, b_ef;
  logic [7:0] b_cnt;
  // DUT C: WIDTH=4, toggle on conflict
  logic       c_en, c_clr;
  logic [1:0] c_mode;
  logic [3:0] c_s, c_r, c_q, c_ch, c_ef;
  logic [7:0] c_cnt;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .CONFLICT(1), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .s(a_s), .r(a_r),
    .err_clr(a_clr), .q(a_q), .changed(a_ch), .err_flag(a_ef), .err_cnt(a_cnt));

  sr_ff_bank #(.WIDTH(4), .CONFLICT(2), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .s(b_s), .r(b_r),
    .err_clr(b_clr), .q(b_q), .changed(b_ch), .err_flag(b_ef), .err_cnt(b_cnt));

  sr_ff_bank #(.WIDTH(4), .CONFLICT(3), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .s(c_s), .r(c_r),
    .err_clr(c_clr), .q(c_q), .changed(c_ch), .err_flag(c_ef), .err_cnt(c_cnt));

  task automatic cmp(input string dut, input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s %s: got %02h expected %02h", dut, nm, fld, act, exp);
    end
  endtask

  task automatic cmp_all(input string dut, input exp_t e, input logic [7:0] q,
                         input logic [7:0] ch, input logic [7:0] ef, input logic [7:0] cnt);
    cmp(dut, e.name, "q", q, e.q);
    cmp(dut, e.name, "changed", ch, e.ch);
    cmp(dut, e.name, "err_flag", ef, e.ef);
    cmp(dut, e.name, "err_cnt", cnt, e.cnt);
  endtask

  // Monitor: every edge, each DUT with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp_all("A", e, a_q, a_ch, a_ef, {6'b0, a_cnt});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp_all("B", e, {4'b0, b_q}, {4'b0, b_ch}, {4'b0, b_ef}, b_cnt);
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp_all("C", e, {4'b0, c_q}, {4'b0, c_ch}, {4'b0, c_ef}, c_cnt);
      end
    end
  end

  task automatic step_a(input logic rst, input logic en, input logic [1:0] mode,
                        input logic [7:0] s, input logic [7:0] r, input logic clr,
                        input logic [7:0] eq, input logic [7:0] ech,
                        input logic [7:0] eef, input logic [7:0] ecnt, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = rst; a_en = en; a_mode = mode; a_s = s; a_r = r; a_clr = clr;
    e.q = eq; e.ch = ech; e.ef = eef; e.cnt = ecnt; e.name = nm;
    qa.push_back(e);
  endtask

  task automatic step_bc(input logic [1:0] mode, input logic [3:0] bs, input logic [3:0] br,
                         input logic [3:0] cs, input logic [3:0] cr,
                         input exp_t eb, input exp_t ec);
    @(negedge clk);
    a_en = 1'b0; a_clr = 1'b0;
    b_en = 1'b1; b_mode = mode; b_s = bs; b_r = br; b_clr = 1'b0;
    c_en = 1'b1; c_mode = mode; c_s = cs; c_r = cr; c_clr = 1'b0;
    qb.push_back(eb);
    qc.push_back(ec);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_mode = M_SR; a_s = 8'hFF; a_r = 8'h00; a_clr = 1'b0;
    b_en = 1'b0; b_mode = M_SR; b_s = 4'h0; b_r = 4'h0; b_clr = 1'b0;
    c_en = 1'b0; c_mode = M_SR; c_s = 4'h0; c_r = 4'h0; c_clr = 1'b0;

    // reset overrides en and set inputs
    step_a(0, 1, M_SR, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, "reset0");
    step_a(0, 1, M_SR, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 8'h00, "reset1");
    // SR with set-dominant conflict on bit 1
    step_a(1, 1, M_SR, 8'h03, 8'h06, 0, 8'h03, 8'h03, 8'h02, 8'h01, "sr_set_dom");
    step_a(1, 1, M_D,  8'h00, 8'hFF, 0, 8'h00, 8'h03, 8'h02, 8'h01, "d_zero");
    // JK toggling never counts as a conflict
    step_a(1, 1, M_JK, 8'hFF, 8'hFF, 0, 8'hFF, 8'hFF, 8'h02, 8'h01, "jk_tog1");
    step_a(1, 1, M_JK, 8'hFF, 8'hFF, 0, 8'h00, 8'hFF, 8'h02, 8'h01, "jk_tog2");
    step_a(1, 1, M_JK, 8'hFF, 8'hFF, 0, 8'hFF, 8'hFF, 8'h02, 8'h01, "jk_tog3");
    step_a(1, 1, M_T,  8'h0F, 8'hFF, 0, 8'hF0, 8'h0F, 8'h02, 8'h01, "t_mode");
    // en gating
    step_a(1, 0, M_D,  8'hA5, 8'h00, 0, 8'hF0, 8'h00, 8'h02, 8'h01, "en_off1");
    step_a(1, 0, M_SR, 8'hFF, 8'hFF, 0, 8'hF0, 8'h00, 8'h02, 8'h01, "en_off_conf");
    step_a(1, 1, M_D,  8'hA5, 8'h00, 0, 8'hA5, 8'h55, 8'h02, 8'h01, "d_load");
    // err_clr acts while en=0
    step_a(1, 0, M_SR, 8'h00, 8'h00, 1, 8'hA5, 8'h00, 8'h00, 8'h00, "clr_en_off");
    // counter saturation at 3
    step_a(1, 1, M_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h00, 8'h01, 8'h01, "sat1");
    step_a(1, 1, M_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h00, 8'h01, 8'h02, "sat2");
    step_a(1, 1, M_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h00, 8'h01, 8'h03, "sat3");
    step_a(1, 1, M_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h00, 8'h01, 8'h03, "sat4");
    step_a(1, 1, M_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h00, 8'h01, 8'h03, "sat5");
    // clear plus conflict in same cycle: conflict survives, count restarts at 1
    step_a(1, 1, M_SR, 8'h11, 8'h11, 1, 8'hB5, 8'h10, 8'h11, 8'h01, "clr_with_conf");
    step_a(1, 1, M_SR, 8'h00, 8'h00, 1, 8'hB5, 8'h00, 8'h00, 8'h00, "clr_alone");
    // mid-sequence reset, then first update on the next edge
    step_a(0, 1, M_D,  8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, "mid_reset");
    step_a(1, 1, M_D,  8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 8'h00, 8'h00, "post_reset");

    // reset-dominant (B) and toggle (C) conflict policies
    begin
      exp_t eb, ec;
      eb.q = 8'h00; eb.ch = 8'h00; eb.ef = 8'h00; eb.cnt = 8'h00; eb.name = "bc_prep";
      ec.q = 8'h02; ec.ch = 8'h02; ec.ef = 8'h00; ec.cnt = 8'h00; ec.name = "bc_prep";
      step_bc(M_D, 4'h0, 4'h0, 4'h2, 4'h0, eb, ec);
      eb.q = 8'h01; eb.ch = 8'h01; eb.ef = 8'h02; eb.cnt = 8'h01; eb.name = "sr_rst_dom";
      ec.q = 8'h01; ec.ch = 8'h03; ec.ef = 8'h02; ec.cnt = 8'h01; ec.name = "sr_toggle";
      step_bc(M_SR, 4'h3, 4'h6, 4'h3, 4'h6, eb, ec);
      eb.q = 8'h01; eb.ch = 8'h00; eb.ef = 8'h0A; eb.cnt = 8'h02; eb.name = "sr_rst_dom2";
      ec.q = 8'h0B; ec.ch = 8'h0A; ec.ef = 8'h0A; ec.cnt = 8'h02; ec.name = "sr_toggle2";
      step_bc(M_SR, 4'hA, 4'hA, 4'hA, 4'hA, eb, ec);
    end

    @(negedge clk);
    b_en = 1'b0; c_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", qa.size() + qb.size() + qc.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time in case the monitor stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

endmodule
